// File: rtl/fc8_audio_pkg.sv
// Shared constants and helpers for the FC8 audio PWM path (generator and capture).
package fc8_audio_pkg;

  localparam int unsigned FC8_PWM_FRAME_LEN = 256;
  localparam int unsigned FC8_SAMPLE_W      = 8;
  localparam logic [FC8_SAMPLE_W-1:0] FC8_SILENCE_LEVEL = 8'h00;

  localparam logic [31:0] FC8_SAMPLE_MAX = (32'd1 << FC8_SAMPLE_W) - 32'd1;

  // Scale a high-cycle count taken over a 2**log2_len frame to sample width, saturating.
  function automatic logic [FC8_SAMPLE_W-1:0] fc8_scale_level(input logic [31:0]  total,
                                                              input int unsigned log2_len);
    logic [31:0] scaled;
    if (log2_len >= FC8_SAMPLE_W) begin
      scaled = total >> (log2_len - FC8_SAMPLE_W);
    end else begin
      scaled = total << (FC8_SAMPLE_W - log2_len);
    end
    return (scaled > FC8_SAMPLE_MAX) ? '1 : scaled[FC8_SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/fc8_sample_fifo.sv
// First-word-fall-through sample FIFO with exact occupancy and a drop indication on full push.
module fc8_sample_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     drop_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] LevelFull = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LevelFull);
  assign level_o = level_q;

  always_comb begin
    do_pop   = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    do_push  = push_i && (!full_o || do_pop);
    drop_o   = push_i && !do_push;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AddrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AddrW + 1)'(1);
      2'b01:   level_d = level_q - (AddrW + 1)'(1);
      default: level_d = level_q;
    endcase
    rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fc8_audio_pwm_capture.sv
// Recovers 8-bit sample levels from the audio PWM stream by counting high cycles per carrier
// frame, buffers them in a FWFT FIFO and flags silence and overflow.
module fc8_audio_pwm_capture
  import fc8_audio_pkg::*;
#(
  parameter int unsigned FRAME_LEN      = FC8_PWM_FRAME_LEN,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SILENCE_FRAMES = 16,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                          audio_clk,
  input  logic                          rst_n,
  input  logic                          pwm_in,
  input  logic                          capture_en,
  output logic [FC8_SAMPLE_W-1:0]       sample_out,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          silence,
  output logic                          frame_tick
);

  localparam int unsigned FcW = $clog2(FRAME_LEN);
  localparam int unsigned HcW = FcW + 1;
  localparam logic [FcW-1:0] FrameLast  = FcW'(FRAME_LEN - 1);
  localparam logic [7:0]     SilenceMax = 8'(SILENCE_FRAMES);

  logic pwm_s;

  if (SYNC_STAGES == 0) begin : g_no_sync
    assign pwm_s = pwm_in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = pwm_in;
    end

    always_ff @(posedge audio_clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= sync_d;
      end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];
  end

  logic [FcW-1:0]          frame_cnt_q, frame_cnt_d;
  logic [HcW-1:0]          high_cnt_q, high_cnt_d;
  logic [HcW-1:0]          total;
  logic                    frame_end;
  logic [FC8_SAMPLE_W-1:0] sample;
  logic [7:0]              sil_cnt_q, sil_cnt_d;
  logic                    silence_q, silence_d;
  logic                    overflow_q, overflow_d;
  logic                    frame_tick_q, frame_tick_d;
  logic                    fifo_empty, fifo_full, fifo_drop;

  always_comb begin
    frame_end = capture_en && (frame_cnt_q == FrameLast);
    total     = high_cnt_q + HcW'(pwm_s);
    sample    = fc8_scale_level(32'(total), FcW);

    // Disabled cycles hold both counters at zero, so re-enabling always starts a fresh frame.
    frame_cnt_d = '0;
    high_cnt_d  = '0;
    if (capture_en && !frame_end) begin
      frame_cnt_d = frame_cnt_q + FcW'(1);
      high_cnt_d  = total;
    end

    sil_cnt_d = sil_cnt_q;
    if (frame_end) begin
      if (sample == FC8_SILENCE_LEVEL) begin
        if (sil_cnt_q != SilenceMax) begin
          sil_cnt_d = sil_cnt_q + 8'd1;
        end
      end else begin
        sil_cnt_d = '0;
      end
    end
    silence_d = (sil_cnt_d == SilenceMax);

    overflow_d = overflow_q;
    if (overflow_clr) begin
      overflow_d = 1'b0;
    end
    if (fifo_drop) begin
      overflow_d = 1'b1;
    end

    frame_tick_d = frame_end;
  end

  always_ff @(posedge audio_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q  <= '0;
      high_cnt_q   <= '0;
      sil_cnt_q    <= '0;
      silence_q    <= 1'b0;
      overflow_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      high_cnt_q   <= high_cnt_d;
      sil_cnt_q    <= sil_cnt_d;
      silence_q    <= silence_d;
      overflow_q   <= overflow_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  fc8_sample_fifo #(
    .Width (FC8_SAMPLE_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (audio_clk),
    .rst_ni  (rst_n),
    .push_i  (frame_end),
    .wdata_i (sample),
    .pop_i   (sample_ready),
    .rdata_o (sample_out),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level),
    .drop_o  (fifo_drop)
  );

  assign sample_valid = !fifo_empty;
  assign overflow     = overflow_q;
  assign silence      = silence_q;
  assign frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_fc8_audio_pwm_capture.sv
// Self-checking bench for fc8_audio_pwm_capture: generator-model PWM stimulus, table of steady
// levels, scoreboard of expected samples, and hand-written FIFO/enable/reset corner sequences.
module tb_fc8_audio_pwm_capture;

  logic       audio_clk = 1'b0;
  logic       rst_n;
  logic       pwm_in;
  logic       capture_en;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       sample_ready;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       overflow_clr;
  logic       silence;
  logic       frame_tick;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         tick_seen = 0;
  int         gen_level = 0;
  logic [7:0] gen_cnt = 8'd0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;

  typedef struct {
    int         level;
    int         frames;
    logic [7:0] exp_sample;
  } vec_t;

  vec_t vecs [6];

  fc8_audio_pwm_capture #(
    .FRAME_LEN      (256),
    .FIFO_DEPTH     (4),
    .SILENCE_FRAMES (16),
    .SYNC_STAGES    (2)
  ) dut (
    .audio_clk    (audio_clk),
    .rst_n        (rst_n),
    .pwm_in       (pwm_in),
    .capture_en   (capture_en),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .silence      (silence),
    .frame_tick   (frame_tick)
  );

  always #500 audio_clk = ~audio_clk;

  // Registered generator model: free-running 8-bit counter, high while count < level.
  initial begin
    pwm_in = 1'b0;
    forever begin
      @(posedge audio_clk);
      #1;
      pwm_in  = (int'(gen_cnt) < gen_level);
      gen_cnt = gen_cnt + 8'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge audio_clk) begin
    if (rst_n) begin
      if (frame_tick) tick_seen++;
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL pop_unexpected: got %02h, expected no sample", sample_out);
        end else begin
          mon_exp = exp_q.pop_front();
          check("pop_sample", {24'd0, sample_out}, {24'd0, mon_exp});
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_sample_out"}, {24'd0, sample_out}, 32'd0);
    check({tag, "_sample_valid"}, {31'd0, sample_valid}, 32'd0);
    check({tag, "_fifo_level"}, {29'd0, fifo_level}, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, "_silence"}, {31'd0, silence}, 32'd0);
    check({tag, "_frame_tick"}, {31'd0, frame_tick}, 32'd0);
  endtask

  // Restart capture on a new level: the pause lets the old waveform leave the sync chain.
  task automatic run_frames(input int level, input int n);
    @(posedge audio_clk); #1;
    capture_en = 1'b0;
    gen_level  = level;
    repeat (4) @(posedge audio_clk);
    #1;
    capture_en = 1'b1;
    repeat (n * 256) @(posedge audio_clk);
    #1;
    capture_en = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 600; i++) begin
      @(posedge audio_clk);
      @(negedge audio_clk);
      if (sample_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_tick(output int ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge audio_clk);
      if (frame_tick) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    #60_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int ok;
    int t0;

    vecs[0] = '{level: 32'h40, frames: 2, exp_sample: 8'h40};
    vecs[1] = '{level: 256,    frames: 2, exp_sample: 8'hFF};
    vecs[2] = '{level: 0,      frames: 2, exp_sample: 8'h00};
    vecs[3] = '{level: 32'hC3, frames: 1, exp_sample: 8'hC3};
    vecs[4] = '{level: 255,    frames: 1, exp_sample: 8'hFF};
    vecs[5] = '{level: 1,      frames: 1, exp_sample: 8'h01};

    rst_n        = 1'b0;
    capture_en   = 1'b0;
    sample_ready = 1'b0;
    overflow_clr = 1'b0;
    #700;
    check_all_zero("reset");
    @(posedge audio_clk); #1;
    rst_n = 1'b1;

    // Level 8'h40: frame end is the 256th enabled cycle, sample visible the cycle after.
    sample_ready = 1'b1;
    gen_level    = 32'h40;
    repeat (4) @(posedge audio_clk);
    #1;
    exp_q.push_back(8'h40);
    capture_en = 1'b1;
    wait_valid(cyc);
    check("first_valid_latency", cyc, 32'd256);
    @(posedge audio_clk); #1;
    capture_en = 1'b0;

    foreach (vecs[i]) begin
      t0 = tick_seen;
      for (int f = 0; f < vecs[i].frames; f++) exp_q.push_back(vecs[i].exp_sample);
      run_frames(vecs[i].level, vecs[i].frames);
      repeat (3) @(posedge audio_clk);
      @(negedge audio_clk);
      check($sformatf("vec%0d_ticks", i), tick_seen - t0, vecs[i].frames);
      check($sformatf("vec%0d_level_drained", i), {29'd0, fifo_level}, 32'd0);
    end

    // Silence: 16th consecutive zero frame asserts, first nonzero frame clears.
    @(posedge audio_clk); #1;
    gen_level = 0;
    repeat (4) @(posedge audio_clk);
    #1;
    for (int k = 0; k < 17; k++) exp_q.push_back(8'h00);
    capture_en = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      wait_tick(ok);
      check($sformatf("silence_tick%0d_seen", k), ok, 32'd1);
      check($sformatf("silence_at_tick%0d", k), {31'd0, silence}, (k >= 16) ? 32'd1 : 32'd0);
    end
    @(posedge audio_clk); #1;
    capture_en = 1'b0;
    gen_level  = 1;
    repeat (4) @(posedge audio_clk);
    @(negedge audio_clk);
    check("silence_holds_disabled", {31'd0, silence}, 32'd1);
    @(posedge audio_clk); #1;
    exp_q.push_back(8'h01);
    capture_en = 1'b1;
    wait_tick(ok);
    check("silence_clear_tick_seen", ok, 32'd1);
    check("silence_cleared", {31'd0, silence}, 32'd0);
    @(posedge audio_clk); #1;
    capture_en = 1'b0;
    repeat (3) @(posedge audio_clk);

    // Overflow: five frames into a depth-4 FIFO with no consumer.
    #1;
    sample_ready = 1'b0;
    for (int l = 1; l <= 4; l++) begin
      exp_q.push_back(8'(l));
      run_frames(l, 1);
    end
    @(negedge audio_clk);
    check("ovf_level_full", {29'd0, fifo_level}, 32'd4);
    check("ovf_not_yet", {31'd0, overflow}, 32'd0);
    run_frames(5, 1);
    @(negedge audio_clk);
    check("ovf_level_after_drop", {29'd0, fifo_level}, 32'd4);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    @(posedge audio_clk); #1;
    sample_ready = 1'b1;
    repeat (8) @(posedge audio_clk);
    @(negedge audio_clk);
    check("ovf_drained", {29'd0, fifo_level}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    @(posedge audio_clk); #1;
    overflow_clr = 1'b1;
    @(posedge audio_clk); #1;
    overflow_clr = 1'b0;
    @(negedge audio_clk);
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO with a pop exactly on the frame-end cycle: push and pop both accepted.
    @(posedge audio_clk); #1;
    sample_ready = 1'b0;
    for (int l = 1; l <= 4; l++) begin
      exp_q.push_back(8'(l * 32'h11));
      run_frames(l * 32'h11, 1);
    end
    exp_q.push_back(8'h55);
    @(posedge audio_clk); #1;
    gen_level = 32'h55;
    repeat (4) @(posedge audio_clk);
    #1;
    capture_en = 1'b1;
    repeat (255) @(posedge audio_clk);
    #1;
    sample_ready = 1'b1;
    @(posedge audio_clk); #1;
    sample_ready = 1'b0;
    capture_en   = 1'b0;
    @(negedge audio_clk);
    check("fullpop_level", {29'd0, fifo_level}, 32'd4);
    check("fullpop_no_ovf", {31'd0, overflow}, 32'd0);
    @(posedge audio_clk); #1;
    sample_ready = 1'b1;
    repeat (8) @(posedge audio_clk);
    @(negedge audio_clk);
    check("fullpop_drained", {29'd0, fifo_level}, 32'd0);

    // capture_en dropped at frame_cnt = 100 for 50 cycles: partial frame discarded.
    @(posedge audio_clk); #1;
    gen_level = 32'h80;
    repeat (4) @(posedge audio_clk);
    #1;
    t0 = tick_seen;
    capture_en = 1'b1;
    repeat (100) @(posedge audio_clk);
    #1;
    capture_en = 1'b0;
    repeat (50) @(posedge audio_clk);
    @(negedge audio_clk);
    check("gap_no_tick", tick_seen - t0, 32'd0);
    check("gap_no_valid", {31'd0, sample_valid}, 32'd0);
    @(posedge audio_clk); #1;
    exp_q.push_back(8'h80);
    capture_en = 1'b1;
    wait_valid(cyc);
    check("reenable_latency", cyc, 32'd256);
    @(posedge audio_clk); #1;
    capture_en = 1'b0;

    // Asynchronous reset mid-frame with queued samples and overflow set.
    sample_ready = 1'b0;
    run_frames(32'h30, 5);
    @(negedge audio_clk);
    check("prerst_level", {29'd0, fifo_level}, 32'd4);
    check("prerst_ovf", {31'd0, overflow}, 32'd1);
    @(posedge audio_clk); #1;
    capture_en = 1'b1;
    repeat (200) @(posedge audio_clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    capture_en = 1'b0;
    @(posedge audio_clk); #1;
    rst_n        = 1'b1;
    sample_ready = 1'b1;
    repeat (4) @(posedge audio_clk);
    #1;
    exp_q.push_back(8'h30);
    capture_en = 1'b1;
    wait_valid(cyc);
    check("post_rst_latency", cyc, 32'd256);
    @(posedge audio_clk); #1;
    capture_en = 1'b0;
    repeat (4) @(posedge audio_clk);
    @(negedge audio_clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
